// File: rtl/mul_div_unit.sv
// Multi-cycle integer multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, sign fix-up in a final cycle.
module mul_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_e_i,
    input  logic [2:0]       op_e_i,
    input  logic [WIDTH-1:0] src_a_e_i,
    input  logic [WIDTH-1:0] src_b_e_i,
    input  logic             abort_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    localparam logic [2:0] OpMult  = 3'b001;
    localparam logic [2:0] OpMultu = 3'b010;
    localparam logic [2:0] OpDiv   = 3'b011;
    localparam logic [2:0] OpDivu  = 3'b100;
    localparam logic [2:0] OpMthi  = 3'b101;
    localparam logic [2:0] OpMtlo  = 3'b110;

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic [WIDTH-1:0]   acc_hi_q, acc_lo_q;
    logic [WIDTH-1:0]   opd_q;
    logic [WIDTH-1:0]   dvd_q;
    logic               is_div_q;
    logic               neg_q, neg_r_q;
    logic               busy_q, done_q;

    // Operand decode for a new operation
    logic               op_signed, op_mul, op_div;
    logic               sign_a, sign_b;
    logic [WIDTH-1:0]   mag_a, mag_b;

    always_comb begin
        op_mul    = (op_e_i == OpMult) || (op_e_i == OpMultu);
        op_div    = (op_e_i == OpDiv) || (op_e_i == OpDivu);
        op_signed = (op_e_i == OpMult) || (op_e_i == OpDiv);
        sign_a    = op_signed & src_a_e_i[WIDTH-1];
        sign_b    = op_signed & src_b_e_i[WIDTH-1];
        mag_a     = sign_a ? (~src_a_e_i + 1'b1) : src_a_e_i;
        mag_b     = sign_b ? (~src_b_e_i + 1'b1) : src_b_e_i;
    end

    // One iteration of either algorithm
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh, rem_diff;
    logic [WIDTH-1:0]   iter_hi, iter_lo;

    always_comb begin
        mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opd_q} : '0);
        rem_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, opd_q};
        if (is_div_q) begin
            // rem_diff[WIDTH] set means the trial subtraction went negative: restore
            if (rem_diff[WIDTH]) begin
                iter_hi = rem_sh[WIDTH-1:0];
                iter_lo = {acc_lo_q[WIDTH-2:0], 1'b0};
            end else begin
                iter_hi = rem_diff[WIDTH-1:0];
                iter_lo = {acc_lo_q[WIDTH-2:0], 1'b1};
            end
        end else begin
            iter_hi = mul_sum[WIDTH:1];
            iter_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
    end

    // Sign fix-up and special cases applied in the final cycle
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    always_comb begin
        prod     = {acc_hi_q, acc_lo_q};
        prod_fix = neg_q ? (~prod + 1'b1) : prod;
        if (!is_div_q) begin
            fix_hi = prod_fix[2*WIDTH-1:WIDTH];
            fix_lo = prod_fix[WIDTH-1:0];
        end else if (opd_q == '0) begin
            fix_hi = dvd_q;
            fix_lo = '1;
        end else begin
            fix_hi = neg_r_q ? (~acc_hi_q + 1'b1) : acc_hi_q;
            fix_lo = neg_q ? (~acc_lo_q + 1'b1) : acc_lo_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opd_q    <= '0;
            dvd_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            neg_r_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort_i) begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start_e_i && (op_mul || op_div)) begin
                            state_q  <= StRun;
                            busy_q   <= 1'b1;
                            cnt_q    <= '0;
                            acc_hi_q <= '0;
                            acc_lo_q <= op_div ? mag_a : mag_b;
                            opd_q    <= op_div ? mag_b : mag_a;
                            dvd_q    <= src_a_e_i;
                            is_div_q <= op_div;
                            neg_q    <= sign_a ^ sign_b;
                            neg_r_q  <= sign_a;
                        end else if (start_e_i && op_e_i == OpMthi) begin
                            hi_q <= src_a_e_i;
                        end else if (start_e_i && op_e_i == OpMtlo) begin
                            lo_q <= src_a_e_i;
                        end
                    end
                    StRun: begin
                        acc_hi_q <= iter_hi;
                        acc_lo_q <= iter_lo;
                        cnt_q    <= cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(WIDTH - 1)) begin
                            state_q <= StFix;
                        end
                    end
                    StFix: begin
                        hi_q    <= fix_hi;
                        lo_q    <= fix_lo;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                    default: begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: stimulus pushes expected HI/LO, a monitor checks on done_o.
module tb_mul_div_unit;

    localparam logic [2:0] OpMult  = 3'b001;
    localparam logic [2:0] OpMultu = 3'b010;
    localparam logic [2:0] OpDiv   = 3'b011;
    localparam logic [2:0] OpDivu  = 3'b100;
    localparam logic [2:0] OpMthi  = 3'b101;
    localparam logic [2:0] OpMtlo  = 3'b110;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        start_e;
    logic [2:0]  op_e;
    logic [31:0] src_a, src_b;
    logic        abort;
    logic        busy, done;
    logic [31:0] hi, lo;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .start_e_i (start_e),
        .op_e_i    (op_e),
        .src_a_e_i (src_a),
        .src_b_e_i (src_b),
        .abort_i   (abort),
        .busy_o    (busy),
        .done_o    (done),
        .hi_o      (hi),
        .lo_o      (lo)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected result
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (rst_i === 1'b1 && done === 1'b1) begin
            logic [63:0] e;
            done_cnt++;
            check("busy_low_with_done", {63'd0, busy}, 64'd0);
            check("done_single_cycle", {63'd0, prev_done}, 64'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("hi", {32'd0, hi}, {32'd0, e[63:32]});
                check("lo", {32'd0, lo}, {32'd0, e[31:0]});
            end
        end
        prev_done = (rst_i === 1'b1) && (done === 1'b1);
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        start_e = 1'b1; op_e = op; src_a = a; src_b = b;
        @(posedge clk); #1;
        start_e = 1'b0; op_e = 3'b000;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy) n++;
            else break;
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        int n, d0;
        exp_q.push_back({eh, el});
        d0 = done_cnt;
        issue(op, a, b);
        wait_idle(n);
        check({name, "_busy_cycles"}, 64'(n), 64'd33);
        @(negedge clk); @(posedge clk);
        check({name, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
    endtask

    initial begin
        int n, d0;
        rst_i = 1'b0; start_e = 1'b0; op_e = 3'b000; src_a = '0; src_b = '0; abort = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b1;
        @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);

        // Reset in the middle of a MULT, with HI/LO preloaded so clearing is visible
        issue(OpMthi, 32'h55, 32'h0);
        issue(OpMtlo, 32'hAA, 32'h0);
        d0 = done_cnt;
        issue(OpMult, 32'd3, 32'd4);
        repeat (4) @(posedge clk);
        #1 rst_i = 1'b0;
        #1;
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_hi", {32'd0, hi}, 64'd0);
        check("midrst_lo", {32'd0, lo}, 64'd0);
        @(posedge clk); #1 rst_i = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("postrst_busy", {63'd0, busy}, 64'd0);
        check("postrst_hi", {32'd0, hi}, 64'd0);
        check("postrst_lo", {32'd0, lo}, 64'd0);
        check("postrst_no_done", 64'(done_cnt - d0), 64'd0);

        run_op("multu_ff", OpMultu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run_op("mult_neg", OpMult, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
        run_op("mult_min", OpMult, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
        run_op("div_neg", OpDiv, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div_negb", OpDiv, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
        run_op("divu", OpDivu, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op("divu_zero", OpDivu, 32'd7, 32'd0, 32'h00000007, 32'hFFFFFFFF);
        run_op("div_zero", OpDiv, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF);
        run_op("div_ovf", OpDiv, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

        // MTHI then MTLO back to back
        @(posedge clk); #1;
        start_e = 1'b1; op_e = OpMthi; src_a = 32'h1234;
        @(posedge clk); #1;
        op_e = OpMtlo; src_a = 32'hABCD;
        @(negedge clk);
        check("mthi_hi", {32'd0, hi}, 64'h1234);
        check("mthi_busy", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;
        start_e = 1'b0; op_e = 3'b000;
        @(negedge clk);
        check("mtlo_lo", {32'd0, lo}, 64'hABCD);
        check("mtlo_hi", {32'd0, hi}, 64'h1234);
        check("mtlo_busy", {63'd0, busy}, 64'd0);

        // Abort in RUN: HI/LO keep preloaded values, no done
        issue(OpMthi, 32'd1, 32'd0);
        issue(OpMtlo, 32'd2, 32'd0);
        d0 = done_cnt;
        issue(OpMult, 32'd6, 32'd7);
        repeat (9) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_hi", {32'd0, hi}, 64'd1);
        check("abort_lo", {32'd0, lo}, 64'd2);
        repeat (40) @(posedge clk);
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);
        check("abort_hold_lo", {32'd0, lo}, 64'd2);

        // Abort beats a simultaneous MTHI
        @(posedge clk); #1;
        start_e = 1'b1; op_e = OpMthi; src_a = 32'hDEAD; abort = 1'b1;
        @(posedge clk); #1;
        start_e = 1'b0; op_e = 3'b000; abort = 1'b0;
        @(negedge clk);
        check("abort_mthi_hi", {32'd0, hi}, 64'd1);

        // Second start while busy is ignored
        exp_q.push_back({32'd0, 32'd42});
        d0 = done_cnt;
        issue(OpMult, 32'd6, 32'd7);
        repeat (3) @(posedge clk);
        #1 start_e = 1'b1; op_e = OpDivu; src_a = 32'd100; src_b = 32'd7;
        @(posedge clk); #1 start_e = 1'b0; op_e = 3'b000;
        wait_idle(n);
        check("busy_start_timeout", {63'd0, busy}, 64'd0);
        @(negedge clk); @(posedge clk);
        check("busy_start_done", 64'(done_cnt - d0), 64'd1);

        repeat (5) @(posedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
Parametrised multi-cycle integer multiply/divide unit with architectural HI/LO registers. It adds MULT/MULTU/DIV/DIVU/MTHI/MTLO support to the pipelined core, which has only single-cycle ALU operations. It sits beside the ALU in the execute stage and accepts an operation when the instruction is in E. busy_o feeds the hazard unit, which stalls any MFHI/MFLO or new mul/div op in D while the unit is busy.

Parameters:
WIDTH, 32, operand/HI/LO width in bits; legal range 4 or more.
CNT_W, $clog2(WIDTH+1), iteration counter width; derived, not overridden.

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous reset, active-low
start_e_i  input  1  operation valid in execute stage this cycle
op_e_i  input  3  000 NONE, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved (treated as NONE)
src_a_e_i  input  WIDTH  rs operand, forwarded value
src_b_e_i  input  WIDTH  rt operand, forwarded value
abort_i  input  1  cancel in-flight operation
busy_o  output  1  multi-cycle operation in progress
done_o  output  1  one-cycle pulse when new HI/LO become visible
hi_o  output  WIDTH  HI register (remainder / product upper half)
lo_o  output  WIDTH  LO register (quotient / product lower half)

Behaviour:
- Reset (rst_i=0, asynchronous): state IDLE; hi_o, lo_o, counter and internal datapath 0; busy_o=0; done_o=0. Reset mid-operation discards the operation.
- FSM states: IDLE, RUN, FIX.
- IDLE + start_e_i + MULT/MULTU/DIV/DIVU:
  - latch operands; for signed ops latch magnitudes and signs.
  - go to RUN, counter=0.
- IDLE + start_e_i + MTHI/MTLO: hi_o/lo_o <= src_a_e_i at that edge. State stays IDLE, busy_o stays 0, done_o stays 0.
- RUN:
  - one iteration per cycle: shift-add multiply, or restoring divide with 1 quotient bit per cycle.
  - after WIDTH iterations go to FIX.
- FIX (1 cycle):
  - signed product: negate the 2*WIDTH product if signs differ.
  - signed divide: quotient sign = sign_a XOR sign_b; remainder takes the sign of the dividend.
  - commit HI/LO at the FIX→IDLE edge; done_o=1 for the following cycle.
- Latency: start sampled at edge 0 → busy_o=1 for WIDTH+1 cycles → HI/LO and done_o updated at edge WIDTH+1. For WIDTH=32: 33 busy cycles.
- busy_o is a registered output: high in RUN and FIX, low in IDLE. It is low in the cycle done_o is high.
- Product: HI = upper WIDTH bits, LO = lower WIDTH bits of the full 2*WIDTH product.
- Divide by zero (signed or unsigned): LO = all ones, HI = src_a unchanged; no trap.
- Signed overflow (most-negative / -1): LO = most-negative, HI = 0.
- start_e_i while busy_o=1: ignored, no state change. The hazard unit is required to prevent this.
- abort_i=1: from any state go to IDLE at the next edge; HI/LO keep their pre-operation values; done_o=0.
- abort_i and start_e_i in the same cycle: abort wins and the start is dropped. This includes MTHI/MTLO.
- NONE/reserved op with start_e_i: no effect.
- hi_o/lo_o change only on MTHI/MTLO, commit, or reset. They are never exposed mid-computation.

Test Plan:
- Reset with rst_i=0 while RUN (cycle 5 of a MULT) → busy_o=0, hi_o=lo_o=0 immediately; after release, IDLE and outputs stay 0.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → busy_o high exactly 33 cycles; then HI=0xFFFFFFFE, LO=0x00000001, done_o high exactly 1 cycle.
- MULT -3 × 5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1. MULT 0x80000000 × 0x80000000 → HI=0x40000000, LO=0x00000000.
- DIV -7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7 / 0 → LO=0xFFFFFFFF, HI=0x00000007. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- MTHI 0x1234 then MTLO 0xABCD on consecutive cycles → hi_o=0x1234 and lo_o=0xABCD, each one cycle after its start; busy_o stays 0.
- Start MULT 6×7 with HI/LO preloaded to 1/2; pulse abort_i in RUN cycle 10 → busy_o=0 next cycle, HI=1, LO=2, no done_o. A second start while busy → ignored, result of the first op unaffected.
